// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux4_rr_arbiter: round-robin grant of a shared 4:1 path, bounded bursts, |
// | single-entry valid/ready output register.          Revision: 1.0         |
// +--------------------------------------------------------------------------+
module mux4_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  input  logic [N-1:0] d_i,
  input  logic         ready_i,
  output logic [3:0]   gnt_o,
  output logic [1:0]   s_o,
  output logic [N-1:0] y_o,
  output logic         yv_o
);

  localparam int unsigned c_cnt_w = $clog2(HOLD + 1);
  localparam logic [c_cnt_w-1:0] c_hold    = c_cnt_w'(HOLD);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [3:0]           gnt_q, gnt_d;
  logic [1:0]           s_q, s_d;
  logic [N-1:0]         y_q, y_d;
  logic                 yv_q, yv_d;

  logic                 w_free;
  logic                 w_acc;
  logic [N-1:0]         w_sel;
  logic [1:0]           w_pick;
  logic                 w_found;
  logic [1:0]           w_idx;

  assign w_free = !yv_q || ready_i;
  assign w_acc  = (state_q == ST_GRANT) && req_i[s_q] && w_free;

  always_comb begin
    w_sel = a_i;
    case (s_q)
      2'd0:    w_sel = a_i;
      2'd1:    w_sel = b_i;
      2'd2:    w_sel = c_i;
      default: w_sel = d_i;
    endcase
  end

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_pick  = ptr_q;
    w_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      w_idx = ptr_q + 2'(k);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    y_d     = y_q;
    yv_d    = yv_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_GRANT;
          s_d     = w_pick;
          gnt_d   = 4'b0001 << w_pick;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (w_acc) begin
          cnt_d = cnt_q + c_cnt_one;
        end
        // S is left untouched on release so the mux stays steady while idle.
        if (!req_i[s_q] || (w_acc && (cnt_q + c_cnt_one == c_hold))) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = s_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    if (w_acc) begin
      y_d  = w_sel;
      yv_d = 1'b1;
    end else if (ready_i) begin
      yv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign gnt_o = gnt_q;
  assign s_o   = s_q;
  assign y_o   = y_q;
  assign yv_o  = yv_q;

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one n-bit 4-to-1 multiplexed path among four requesters A–D. It grants the path to one requester at a time and drives the mux select. It also registers the selected word into a single-entry valid/ready output stage. The block sits between four producer ports and one downstream consumer, and bounds each grant to a fixed number of beats for fairness.

## Interface
- n, 4, data width of A, B, C, D and Y
- HOLD, 4, maximum beats per grant (HOLD ≥ 1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- REQ  input  4  request per port; bit 0 = A, 1 = B, 2 = C, 3 = D
- A, B, C, D  input  n  port data; sampled only on an accepted beat
- READY  input  1  downstream can take Y this cycle
- GNT  output  4  one-hot grant, registered; 0 when idle
- S  output  2  registered mux select (00 = A, 01 = B, 10 = C, 11 = D)
- Y  output  n  registered output word
- YV  output  1  Y holds a valid word

## Operation
- Reset state (rst = 1 at a rising edge):
  - state = IDLE, GNT = 0000, S = 00, Y = 0, YV = 0
  - priority pointer PTR = 0, beat count CNT = 0
  - rst overrides all other inputs. Reset during a burst drops the burst and any word in Y.
- The output stage can load when `free = !YV || READY`.
- A beat is accepted when `acc = (state == GRANT) && REQ[S] && free`.
  - On acc: Y ← port[S], YV ← 1, CNT ← CNT + 1.
  - With !acc and READY: YV ← 0. Otherwise Y and YV hold.
- IDLE:
  - If REQ = 0, stay in IDLE.
  - Otherwise grant the first set REQ bit scanning PTR, PTR+1, … mod 4. Set S to that index and GNT = 1 << S, clear CNT, and go to GRANT.
- GRANT: the grant is released when either of these holds:
  - REQ[S] = 0, whether or not any beat was transferred
  - acc with CNT + 1 == HOLD
- On release:
  - GNT ← 0000, PTR ← S + 1 (mod 4), state ← IDLE.
  - S holds its last value.
  - Y/YV continue to drain independently of the grant.
- When the grant holder lowers REQ while READY is low, no beat is lost: there was no acc, so there was no data.
- Arbitration evaluates only in IDLE. A request arriving in GRANT waits.
- CNT width is clog2(HOLD+1) bits. CNT never exceeds HOLD.
- GNT is always one-hot or zero. S always equals the index of the set GNT bit while in GRANT.

## Timing
- REQ rises in cycle t with the block idle → GNT/S valid in cycle t+1.
- The first acc can occur in cycle t+1. Y/YV are valid in cycle t+2.
- Back-to-back beats sustain 1 word/cycle while READY = 1.
- After release there is one IDLE cycle (bubble) before the next grant.
  - Worst-case gap between consecutive grants is 1 cycle.
  - Worst-case wait for a requesting port is 3 × (HOLD + 1) cycles plus downstream stall time.
- With READY = 0 and YV = 1, acc is blocked and CNT holds. The grant persists until READY or a REQ drop.
- If the grant holder drops REQ in the same cycle another port raises REQ: release happens that cycle, and the new grant is issued one cycle later.

## Test plan
- Reset: assert rst for 2 cycles with REQ = 1111 and READY = 1 → GNT = 0000, S = 00, Y = 0, YV = 0 throughout. Then B wins first after rst deasserts? No: A wins (PTR = 0), with GNT = 0001 one cycle after rst drops.
- Single burst, HOLD = 4: REQ = 0100 held, C = 0x5, READY = 1.
  - GNT = 0100 and S = 10 for exactly 4 cycles, then 1 idle cycle, then re-grant to C.
  - YV is high for 4 consecutive cycles with Y = 0x5.
- Round-robin fairness: REQ = 1111 constant, READY = 1.
  - Grant order is A, B, C, D, A, each lasting 4 beats.
  - Each burst is separated by exactly 1 cycle with GNT = 0000.
- Backpressure: grant A with A = 0x3 and READY = 0 for 5 cycles.
  - Y = 0x3 with YV = 1 is held steady and CNT stays at 1.
  - READY = 1 resumes the burst with no word duplicated or dropped; 4 total beats.
- Early release: grant D, then drop REQ[3] after 2 beats while REQ[1] = 1.
  - GNT goes to 0000 the next cycle, then to 0010 (S = 01) one cycle later.
  - PTR wrapped to 0, but B wins because A is not requesting.
- Reset mid-burst: assert rst during beat 2 of a grant to B with YV = 1.
  - Next cycle GNT = 0000, YV = 0, Y = 0.
  - The next arbitration starts from PTR = 0.
